// File: rtl/apb_i2c_arbiter.sv
// Two-port APB arbiter in front of one APB I2C master peripheral.
// An idle-timeout ownership lock keeps each requester's register sequences intact.
module apb_i2c_arbiter #(
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic        PCLK,
    input  logic        PRESETn,

    input  logic        s0_PSEL,
    input  logic        s0_PENABLE,
    input  logic        s0_PWRITE,
    input  logic [31:0] s0_PADDR,
    input  logic [31:0] s0_PWDATA,
    output logic [31:0] s0_PRDATA,
    output logic        s0_PREADY,

    input  logic        s1_PSEL,
    input  logic        s1_PENABLE,
    input  logic        s1_PWRITE,
    input  logic [31:0] s1_PADDR,
    input  logic [31:0] s1_PWDATA,
    output logic [31:0] s1_PRDATA,
    output logic        s1_PREADY,

    output logic        m_PSEL,
    output logic        m_PENABLE,
    output logic        m_PWRITE,
    output logic [31:0] m_PADDR,
    output logic [31:0] m_PWDATA,
    input  logic [31:0] m_PRDATA,
    input  logic        m_PREADY,

    input  logic        irq_i,
    output logic        irq0_o,
    output logic        irq1_o,

    output logic [1:0]  fsm_state
);

    // Handshake: a requester is active while its PSEL is high and must hold its
    // address, data and direction until it samples its PREADY high for one cycle;
    // the peripheral side is a standard APB setup phase followed by an access
    // phase that ends on the first cycle m_PREADY is sampled high.

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    localparam logic [7:0] TIMEOUT = 8'(LOCK_TIMEOUT);
    localparam logic       LOCK_EN = 1'(LOCK_TIMEOUT != 0);

    state_t     state;
    logic       owner;
    logic       locked;
    logic [7:0] idle_cnt;

    logic owner_req;
    logic other_req;
    logic timed_out;
    logic grant_valid;
    logic grant_sel;

    // PENABLE of the requesters carries no information the arbiter needs.
    logic penable_unused;
    assign penable_unused = s0_PENABLE ^ s1_PENABLE;

    assign fsm_state = state;
    assign irq0_o    = irq_i & ~owner;
    assign irq1_o    = irq_i & owner;

    always_comb begin
        owner_req   = owner ? s1_PSEL : s0_PSEL;
        other_req   = owner ? s0_PSEL : s1_PSEL;
        timed_out   = (idle_cnt >= TIMEOUT);
        grant_valid = 1'b0;
        grant_sel   = owner;
        if (locked) begin
            if (owner_req) begin
                grant_valid = 1'b1;
                grant_sel   = owner;
            end else if (other_req && timed_out) begin
                grant_valid = 1'b1;
                grant_sel   = ~owner;
            end
        end else if (s0_PSEL && s1_PSEL) begin
            grant_valid = 1'b1;
            grant_sel   = ~owner;
        end else if (s0_PSEL || s1_PSEL) begin
            grant_valid = 1'b1;
            grant_sel   = s1_PSEL;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            owner     <= 1'b0;
            locked    <= 1'b0;
            idle_cnt  <= 8'd0;
            m_PSEL    <= 1'b0;
            m_PENABLE <= 1'b0;
            m_PWRITE  <= 1'b0;
            m_PADDR   <= 32'd0;
            m_PWDATA  <= 32'd0;
            s0_PRDATA <= 32'd0;
            s1_PRDATA <= 32'd0;
            s0_PREADY <= 1'b0;
            s1_PREADY <= 1'b0;
        end else begin
            s0_PREADY <= 1'b0;
            s1_PREADY <= 1'b0;
            case (state)
                IDLE: begin
                    // Owner silent while locked: age the lock; release once it has expired.
                    if (locked && !owner_req) begin
                        if (idle_cnt != 8'hFF) begin
                            idle_cnt <= idle_cnt + 8'd1;
                        end
                        if (timed_out) begin
                            locked <= 1'b0;
                        end
                    end
                    if (grant_valid) begin
                        owner     <= grant_sel;
                        locked    <= LOCK_EN;
                        idle_cnt  <= 8'd0;
                        m_PADDR   <= grant_sel ? s1_PADDR  : s0_PADDR;
                        m_PWDATA  <= grant_sel ? s1_PWDATA : s0_PWDATA;
                        m_PWRITE  <= grant_sel ? s1_PWRITE : s0_PWRITE;
                        m_PSEL    <= 1'b1;
                        m_PENABLE <= 1'b0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    m_PENABLE <= 1'b1;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    if (m_PREADY) begin
                        if (!m_PWRITE) begin
                            if (owner) begin
                                s1_PRDATA <= m_PRDATA;
                            end else begin
                                s0_PRDATA <= m_PRDATA;
                            end
                        end
                        if (owner) begin
                            s1_PREADY <= 1'b1;
                        end else begin
                            s0_PREADY <= 1'b1;
                        end
                        m_PSEL    <= 1'b0;
                        m_PENABLE <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_i2c_arbiter.sv
// Bench for apb_i2c_arbiter: directed and randomized requester traffic against
// a memory model, with a scoreboard on both requester ports.
module tb_apb_i2c_arbiter;

    localparam int LT       = 4;
    localparam int BASE_LAT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic [31:0] paddr   [2];
    logic [31:0] pwdata  [2];

    logic [31:0] s0_prdata, s1_prdata;
    logic        s0_pready, s1_pready;
    logic        m_psel, m_penable, m_pwrite;
    logic [31:0] m_paddr, m_pwdata;
    logic [31:0] m_prdata;
    logic        m_pready;
    logic        irq, irq0, irq1;
    logic [1:0]  dbg_state_unused;

    apb_i2c_arbiter #(.LOCK_TIMEOUT(LT)) u_dut (
        .PCLK(clk), .PRESETn(rst_n),
        .s0_PSEL(psel[0]), .s0_PENABLE(penable[0]), .s0_PWRITE(pwrite[0]),
        .s0_PADDR(paddr[0]), .s0_PWDATA(pwdata[0]), .s0_PRDATA(s0_prdata), .s0_PREADY(s0_pready),
        .s1_PSEL(psel[1]), .s1_PENABLE(penable[1]), .s1_PWRITE(pwrite[1]),
        .s1_PADDR(paddr[1]), .s1_PWDATA(pwdata[1]), .s1_PRDATA(s1_prdata), .s1_PREADY(s1_pready),
        .m_PSEL(m_psel), .m_PENABLE(m_penable), .m_PWRITE(m_pwrite),
        .m_PADDR(m_paddr), .m_PWDATA(m_pwdata), .m_PRDATA(m_prdata), .m_PREADY(m_pready),
        .irq_i(irq), .irq0_o(irq0), .irq1_o(irq1), .fsm_state(dbg_state_unused)
    );

    // Second instance without locking; both requesters hold PSEL permanently.
    logic [31:0] b_s0_prdata, b_s1_prdata, b_m_paddr, b_m_pwdata;
    logic        b_s0_pready, b_s1_pready, b_m_psel, b_m_penable, b_m_pwrite;
    logic        b_irq0, b_irq1;
    logic [1:0]  b_state_unused;

    apb_i2c_arbiter #(.LOCK_TIMEOUT(0)) u_rr (
        .PCLK(clk), .PRESETn(rst_n),
        .s0_PSEL(1'b1), .s0_PENABLE(1'b1), .s0_PWRITE(1'b1),
        .s0_PADDR(32'h0000_00B0), .s0_PWDATA(32'h1111_0000), .s0_PRDATA(b_s0_prdata), .s0_PREADY(b_s0_pready),
        .s1_PSEL(1'b1), .s1_PENABLE(1'b1), .s1_PWRITE(1'b1),
        .s1_PADDR(32'h0000_00B4), .s1_PWDATA(32'h2222_0000), .s1_PRDATA(b_s1_prdata), .s1_PREADY(b_s1_pready),
        .m_PSEL(b_m_psel), .m_PENABLE(b_m_penable), .m_PWRITE(b_m_pwrite),
        .m_PADDR(b_m_paddr), .m_PWDATA(b_m_pwdata), .m_PRDATA(32'd0), .m_PREADY(1'b1),
        .irq_i(1'b0), .irq0_o(b_irq0), .irq1_o(b_irq1), .fsm_state(b_state_unused)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: flat memory plus the last read value seen by each port.
    logic [31:0] model_mem [logic [31:0]];
    logic [31:0] last_rd   [2];
    logic [31:0] exp_q0 [$];
    logic [31:0] exp_q1 [$];

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        return model_mem.exists(addr) ? model_mem[addr] : 32'd0;
    endfunction

    // Peripheral: memory with a configurable number of wait states (-1 = random).
    logic [31:0] pmem [logic [31:0]];
    int          wait_cfg = 0;
    int          waits_left = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_pready   = 1'b0;
            waits_left = 0;
        end else if (m_psel && m_penable) begin
            if (waits_left > 0) begin
                waits_left--;
                m_pready = 1'b0;
            end else begin
                m_pready = 1'b1;
                if (m_pwrite) pmem[m_paddr] = m_pwdata;
                else m_prdata = pmem.exists(m_paddr) ? pmem[m_paddr] : 32'd0;
            end
        end else begin
            m_pready   = 1'b0;
            waits_left = (wait_cfg < 0) ? int'($urandom_range(0, 3)) : wait_cfg;
        end
    end

    // Monitor: scoreboard on requester completions and checks on the peripheral side.
    logic        prev_pr [2] = '{1'b0, 1'b0};
    int          grant_log [$];
    int          b_grants [$];
    int          cur_setup = 0, cur_access = 0;
    logic        prev_setup = 1'b0;
    logic [31:0] setup_addr = '0, setup_wdata = '0;
    logic        setup_write = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_pr    = '{1'b0, 1'b0};
            prev_setup = 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                logic        pr;
                logic [31:0] dat;
                pr  = (k == 0) ? s0_pready : s1_pready;
                dat = (k == 0) ? s0_prdata : s1_prdata;
                if (pr) begin
                    check(k == 0 ? "s0_pready_has_req" : "s1_pready_has_req", psel[k], 1'b1);
                    check(k == 0 ? "s0_pready_single" : "s1_pready_single", prev_pr[k], 1'b0);
                    if (k == 0 && exp_q0.size() > 0) check("s0_prdata", dat, exp_q0.pop_front());
                    else if (k == 1 && exp_q1.size() > 0) check("s1_prdata", dat, exp_q1.pop_front());
                    else check(k == 0 ? "s0_unexpected_pready" : "s1_unexpected_pready", 1'b1, 1'b0);
                end
                prev_pr[k] = pr;
            end
            if (m_psel && !m_penable) begin
                int port;
                port = -1;
                if (psel[0] && paddr[0] == m_paddr && pwrite[0] == m_pwrite &&
                    (!m_pwrite || pwdata[0] == m_pwdata)) port = 0;
                else if (psel[1] && paddr[1] == m_paddr && pwrite[1] == m_pwrite &&
                    (!m_pwrite || pwdata[1] == m_pwdata)) port = 1;
                check("m_matches_request", 32'(port >= 0), 32'd1);
                grant_log.push_back(port);
                cur_setup   = prev_setup ? cur_setup + 1 : 1;
                cur_access  = 0;
                setup_addr  = m_paddr;
                setup_wdata = m_pwdata;
                setup_write = m_pwrite;
            end else if (m_psel && m_penable) begin
                cur_access++;
                check("m_paddr_stable", m_paddr, setup_addr);
                check("m_pwdata_stable", m_pwdata, setup_wdata);
                check("m_pwrite_stable", m_pwrite, setup_write);
            end
            prev_setup = m_psel && !m_penable;
            if (b_m_psel && !b_m_penable) b_grants.push_back(b_m_paddr == 32'h0000_00B4 ? 1 : 0);
        end
    end

    // Requester driver. Called with time just after a rising edge.
    task automatic xfer(input int k, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat, output int done_cyc);
        logic [31:0] exp;
        int          start;
        int          n;
        if (wr) begin
            model_mem[addr] = wdata;
            exp = last_rd[k];
        end else begin
            exp = model_read(addr);
            last_rd[k] = exp;
        end
        if (k == 0) exp_q0.push_back(exp);
        else exp_q1.push_back(exp);
        psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr; paddr[k] = addr; pwdata[k] = wdata;
        start    = cyc;
        lat      = -1;
        done_cyc = -1;
        n        = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                if (k == 0) void'(exp_q0.pop_back());
                else void'(exp_q1.pop_back());
                break;
            end
            if ((k == 0) ? s0_pready : s1_pready) begin
                done_cyc = cyc;
                lat      = cyc - start;
                break;
            end
            if (cyc - start == 1) penable[k] = 1'b1;
            n++;
            if (n > 300) begin
                total++; bad++;
                $display("FAIL xfer_timeout port %0d: got no PREADY want PREADY within 300 cycles", k);
                break;
            end
        end
        @(posedge clk);
        #1;
        psel[k] = 1'b0; penable[k] = 1'b0;
    endtask

    task automatic idle(input int g);
        if (g > 0) begin
            repeat (g) @(posedge clk);
            #1;
        end
    endtask

    task automatic rand_traffic(input int k, input int n);
        int          lat, dc;
        logic [31:0] base;
        base = (k == 0) ? 32'h0000_1000 : 32'h0000_2000;
        for (int i = 0; i < n; i++) begin
            idle($urandom_range(0, 6));
            xfer(k, 1'($urandom_range(0, 1)), base + 32'(4 * $urandom_range(0, 7)), $urandom, lat, dc);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before 500000");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, dc, s0_done, s1_done, gl_start, rr_owner, n;
        for (int k = 0; k < 2; k++) begin
            psel[k] = 1'b0; penable[k] = 1'b0; pwrite[k] = 1'b0; paddr[k] = '0; pwdata[k] = '0;
            last_rd[k] = '0;
        end
        rst_n    = 1'b0;
        irq      = 1'b1;
        m_prdata = '0;
        m_pready = 1'b0;
        pmem[32'h0000_0F04]      = 32'h0000_0081;
        model_mem[32'h0000_0F04] = 32'h0000_0081;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mctl", {29'd0, m_psel, m_penable, m_pwrite}, 32'd0);
        check("rst_maddr", m_paddr, 32'd0);
        check("rst_mwdata", m_pwdata, 32'd0);
        check("rst_prdata", s0_prdata | s1_prdata, 32'd0);
        check("rst_pready", {30'd0, s0_pready, s1_pready}, 32'd0);
        check("rst_irq", {30'd0, irq0, irq1}, 32'd2);
        irq = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single write with one peripheral wait state.
        wait_cfg = 1;
        xfer(0, 1'b1, 32'h0000_0F08, 32'h0000_01FF, lat, dc);
        check("wr_latency", lat, BASE_LAT + 1);
        check("wr_setup_cycles", cur_setup, 1);
        check("wr_access_cycles", cur_access, 2);
        check("wr_m_paddr", setup_addr, 32'h0000_0F08);
        check("wr_m_pwdata", setup_wdata, 32'h0000_01FF);
        check("wr_periph_mem", pmem[32'h0000_0F08], 32'h0000_01FF);

        // Read by s1 while s0 still holds the lock.
        wait_cfg = 0;
        xfer(1, 1'b0, 32'h0000_0F04, 32'd0, lat, dc);
        check("rd_lock_latency", lat, LT + BASE_LAT);
        check("rd_prdata_held", s1_prdata, 32'h0000_0081);
        irq = 1'b1; #1;
        check("irq_to_owner1", {30'd0, irq0, irq1}, 32'd1);
        irq = 1'b0;

        // Lock hold: s0 bursts with short gaps, s1 requests throughout.
        idle(10);
        gl_start = grant_log.size();
        s0_done = 0; s1_done = 0;
        fork
            begin
                int l0, d0;
                for (int i = 0; i < 4; i++) begin
                    xfer(0, 1'b1, 32'h0000_1000 + 32'(4 * i), $urandom, l0, d0);
                    s0_done = d0;
                    if (i < 3) idle(2);
                end
            end
            begin
                int l1, d1;
                idle(1);
                xfer(1, 1'b1, 32'h0000_2000, $urandom, l1, d1);
                s1_done = d1;
            end
        join
        check("lock_handover_cycles", s1_done - s0_done, LT + 4);
        check("lock_grant_count", grant_log.size() - gl_start, 5);
        for (int i = 0; i < 5; i++) begin
            if (gl_start + i < grant_log.size())
                check("lock_grant_order", grant_log[gl_start + i], (i < 4) ? 0 : 1);
        end

        // Randomized concurrent traffic with random wait states.
        wait_cfg = -1;
        fork
            rand_traffic(0, 12);
            rand_traffic(1, 12);
        join
        wait_cfg = 0;

        // Round-robin instance: owner starts at 0, so grants go 1,0,1,0,...
        check("rr_grant_count_min", 32'(b_grants.size() >= 6), 32'd1);
        rr_owner = 0;
        for (int i = 0; i < 6 && i < b_grants.size(); i++) begin
            rr_owner = 1 - rr_owner;
            check("rr_grant_order", b_grants[i], rr_owner);
        end

        // Asynchronous reset during a stalled access phase.
        wait_cfg = 1000;
        fork
            xfer(0, 1'b0, 32'h0000_1000, 32'd0, lat, dc);
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!(m_psel && m_penable) && n < 50);
                check("arst_reached_access", {31'd0, m_psel && m_penable}, 32'd1);
                #2 rst_n = 1'b0;
                #1;
                check("arst_mctl", {29'd0, m_psel, m_penable, m_pwrite}, 32'd0);
                check("arst_maddr", m_paddr, 32'd0);
                check("arst_prdata", s0_prdata | s1_prdata, 32'd0);
                check("arst_pready", {30'd0, s0_pready, s1_pready}, 32'd0);
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
            end
        join
        check("arst_aborted", lat, 32'hFFFF_FFFF);
        last_rd[0] = '0;
        last_rd[1] = '0;
        wait_cfg   = 0;
        @(posedge clk); #1;
        xfer(0, 1'b1, 32'h0000_1004, 32'hA5A5_0001, lat, dc);
        check("post_rst_latency", lat, BASE_LAT);
        xfer(0, 1'b0, 32'h0000_1004, 32'd0, lat, dc);
        check("post_rst_read", s0_prdata, 32'hA5A5_0001);

        idle(3);
        check("exp_queue_empty", exp_q0.size() + exp_q1.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
